ysyx_22040237_idu_stage: RTL

- Registered, handshaked instruction-decode stage. It succeeds the single-cycle IDU as the ID stage of the pipelined core.
- It takes {pc, inst} from IFU over a valid/ready handshake and reads the register file combinationally.
- It decodes an extended RV64I subset into ALU opcode, operands, jump, memory and writeback controls. These are held in one output pipeline register with valid/ready towards EXU.
- It adds flush, ebreak halt state and a sticky invalid-instruction flag.

---
 rtl/ysyx_22040237_idu_stage.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040237_idu_stage.sv
// Registered, handshaked ID stage. Decodes an extended RV64I subset into one output
// pipeline register towards EXU, with flush, ebreak halt and a sticky invalid flag.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | normal operation, instructions accepted from IFU
//   ST_HALT | ebreak accepted; input closed until reset, last bundle drains
module ysyx_22040237_idu_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    output logic            rs1_r_en,
    output logic [4:0]      rs1_r_addr,
    output logic            rs2_r_en,
    output logic [4:0]      rs2_r_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [7:0]      out_alu_op,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic            out_jump,
    output logic            out_branch,
    output logic [PC_W-1:0] out_jump_base,
    output logic [PC_W-1:0] out_jump_off,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_rd_w_en,
    output logic [4:0]      out_rd_w_addr,
    output logic            out_ebreak,
    output logic            out_invalid,
    output logic            halted,
    output logic            invalid_seen
);

    localparam logic [7:0] ALU_NOP  = 8'h00;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SLT  = 8'h02;
    localparam logic [7:0] ALU_SLTU = 8'h03;
    localparam logic [7:0] ALU_XOR  = 8'h04;
    localparam logic [7:0] ALU_OR   = 8'h05;
    localparam logic [7:0] ALU_AND  = 8'h06;
    localparam logic [7:0] ALU_EQ   = 8'h08;
    localparam logic [7:0] ALU_NE   = 8'h09;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic {ST_RUN, ST_HALT} state_t;
    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_x;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign rd     = in_inst[11:7];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign pc_x   = XLEN'(in_pc);

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    logic [7:0]      d_alu_op;
    logic [XLEN-1:0] d_op1, d_op2, d_store;
    logic [PC_W-1:0] d_base, d_off;
    logic            d_jump, d_branch, d_mem_rd, d_mem_wr, d_rd_en, d_ebreak, d_invalid;
    logic            d_rs1_en, d_rs2_en, d_rd_w_en;

    always_comb begin
        d_alu_op  = ALU_NOP;
        d_op1     = '0;
        d_op2     = '0;
        d_store   = '0;
        d_base    = '0;
        d_off     = '0;
        d_jump    = 1'b0;
        d_branch  = 1'b0;
        d_mem_rd  = 1'b0;
        d_mem_wr  = 1'b0;
        d_rd_en   = 1'b0;
        d_ebreak  = 1'b0;
        d_invalid = 1'b0;
        d_rs1_en  = 1'b0;
        d_rs2_en  = 1'b0;
        if (in_inst == 32'h0) begin
            d_alu_op = ALU_NOP;
        end else if (in_inst == INST_EBREAK) begin
            d_ebreak = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM: begin
                    d_rs1_en = 1'b1;
                    d_rd_en  = 1'b1;
                    d_op1    = rs1_data;
                    d_op2    = imm_i;
                    case (funct3)
                        3'b000:  d_alu_op = ALU_ADD;
                        3'b010:  d_alu_op = ALU_SLT;
                        3'b011:  d_alu_op = ALU_SLTU;
                        3'b100:  d_alu_op = ALU_XOR;
                        3'b110:  d_alu_op = ALU_OR;
                        3'b111:  d_alu_op = ALU_AND;
                        default: d_invalid = 1'b1;
                    endcase
                end
                OPC_LUI: begin
                    d_rd_en  = 1'b1;
                    d_alu_op = ALU_ADD;
                    d_op2    = imm_u;
                end
                OPC_AUIPC: begin
                    d_rd_en  = 1'b1;
                    d_alu_op = ALU_ADD;
                    d_op1    = pc_x;
                    d_op2    = imm_u;
                end
                OPC_JAL: begin
                    d_rd_en  = 1'b1;
                    d_alu_op = ALU_ADD;
                    d_op1    = pc_x;
                    d_op2    = XLEN'(4);
                    d_jump   = 1'b1;
                    d_base   = in_pc;
                    d_off    = PC_W'(imm_j);
                end
                OPC_JALR: begin
                    if (funct3 == 3'b000) begin
                        d_rs1_en = 1'b1;
                        d_rd_en  = 1'b1;
                        d_alu_op = ALU_ADD;
                        d_op1    = pc_x;
                        d_op2    = XLEN'(4);
                        d_jump   = 1'b1;
                        d_base   = rs1_data[PC_W-1:0];
                        d_off    = PC_W'(imm_i);
                    end else begin
                        d_invalid = 1'b1;
                    end
                end
                OPC_LOAD: begin
                    if (funct3 == 3'b011) begin
                        d_rs1_en = 1'b1;
                        d_rd_en  = 1'b1;
                        d_alu_op = ALU_ADD;
                        d_op1    = rs1_data;
                        d_op2    = imm_i;
                        d_mem_rd = 1'b1;
                    end else begin
                        d_invalid = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (funct3 == 3'b011) begin
                        d_rs1_en = 1'b1;
                        d_rs2_en = 1'b1;
                        d_alu_op = ALU_ADD;
                        d_op1    = rs1_data;
                        d_op2    = imm_s;
                        d_mem_wr = 1'b1;
                        d_store  = rs2_data;
                    end else begin
                        d_invalid = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    if (funct3 == 3'b000 || funct3 == 3'b001) begin
                        d_rs1_en = 1'b1;
                        d_rs2_en = 1'b1;
                        d_alu_op = (funct3 == 3'b000) ? ALU_EQ : ALU_NE;
                        d_op1    = rs1_data;
                        d_op2    = rs2_data;
                        d_branch = 1'b1;
                        d_base   = in_pc;
                        d_off    = PC_W'(imm_b);
                    end else begin
                        d_invalid = 1'b1;
                    end
                end
                default: d_invalid = 1'b1;
            endcase
        end
        // An undecodable word must leave no partially-decoded enables behind.
        if (d_invalid) begin
            d_alu_op = ALU_NOP;
            d_op1    = '0;
            d_op2    = '0;
            d_rs1_en = 1'b0;
            d_rs2_en = 1'b0;
            d_rd_en  = 1'b0;
            d_jump   = 1'b0;
            d_base   = '0;
            d_off    = '0;
        end
    end

    assign d_rd_w_en  = d_rd_en & (rd != 5'd0);
    assign rs1_r_en   = d_rs1_en;
    assign rs2_r_en   = d_rs2_en;
    assign rs1_r_addr = d_rs1_en ? rs1 : 5'd0;
    assign rs2_r_addr = d_rs2_en ? rs2 : 5'd0;

    logic accept;
    assign halted   = (state == ST_HALT);
    assign in_ready = ~halted & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            invalid_seen   <= 1'b0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_alu_op     <= '0;
            out_op1        <= '0;
            out_op2        <= '0;
            out_jump       <= 1'b0;
            out_branch     <= 1'b0;
            out_jump_base  <= '0;
            out_jump_off   <= '0;
            out_mem_rd     <= 1'b0;
            out_mem_wr     <= 1'b0;
            out_store_data <= '0;
            out_rd_w_en    <= 1'b0;
            out_rd_w_addr  <= '0;
            out_ebreak     <= 1'b0;
            out_invalid    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_pc         <= in_pc;
            out_alu_op     <= d_alu_op;
            out_op1        <= d_op1;
            out_op2        <= d_op2;
            out_jump       <= d_jump;
            out_branch     <= d_branch;
            out_jump_base  <= d_base;
            out_jump_off   <= d_off;
            out_mem_rd     <= d_mem_rd;
            out_mem_wr     <= d_mem_wr;
            out_store_data <= d_store;
            out_rd_w_en    <= d_rd_w_en;
            out_rd_w_addr  <= d_rd_w_en ? rd : 5'd0;
            out_ebreak     <= d_ebreak;
            out_invalid    <= d_invalid;
            if (d_invalid)
                invalid_seen <= 1'b1;
            if (d_ebreak)
                state <= ST_HALT;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
